// File: rtl/accum_real_pkg.sv
// accum_real_pkg: shared types and helpers for the fixed-point block accumulator.
package accum_real_pkg;

    typedef enum logic {ACC, DONE} state_t;

    localparam int SAT_W = 64;

    typedef struct packed {
        logic                    sat;
        logic signed [SAT_W-1:0] mant;
    } sat_t;

    function automatic int align_shift(int in_exp, int out_exp);
        return in_exp - out_exp;
    endfunction

    // Head-room for COUNT_WIDTH worth of full-scale samples plus the left shift.
    function automatic int acc_width(int in_w, int out_w, int cnt_w, int shift);
        return (in_w > out_w ? in_w : out_w) + cnt_w + (shift > 0 ? shift : 0);
    endfunction

    function automatic sat_t sat_to_width(logic signed [SAT_W-1:0] value, int width);
        logic signed [SAT_W-1:0] lo;
        logic signed [SAT_W-1:0] hi;
        sat_t r;
        lo     = -(64'sd1 <<< (width - 1));
        hi     = ~lo;
        r.sat  = (value > hi) || (value < lo);
        r.mant = value > hi ? hi : (value < lo ? lo : value);
        return r;
    endfunction

endpackage

// File: rtl/accum_real_align.sv
// align_real_sig: sign-extends a fixed-point mantissa and moves it between binary exponents.
module align_real_sig #(
    parameter int IN_WIDTH     = 16,
    parameter int IN_EXPONENT  = -8,
    parameter int OUT_EXPONENT = -8,
    parameter int OUT_WIDTH    = 24
) (
    input  logic        [IN_WIDTH-1:0]  data_i,
    output logic signed [OUT_WIDTH-1:0] data_o
);

    localparam int SH  = IN_EXPONENT - OUT_EXPONENT;
    localparam int SHL = SH > 0 ? SH : 0;
    localparam int SHR = SH < 0 ? -SH : 0;

    logic signed [OUT_WIDTH-1:0] ext;

    assign ext = OUT_WIDTH'($signed(data_i));
    // Arithmetic right shift floors toward -inf, which is the required truncation.
    assign data_o = (ext <<< SHL) >>> SHR;

endmodule

// File: rtl/accum_real.sv
// accum_real: sums cfg_len aligned signed samples per block and presents a saturated result
// on a valid/ready output, accepting the next block's first sample on the same cycle it is taken.
module accum_real
    import accum_real_pkg::*;
#(
    parameter int IN_WIDTH     = 16,
    parameter int IN_EXPONENT  = -8,
    parameter int OUT_WIDTH    = 16,
    parameter int OUT_EXPONENT = -8,
    parameter int COUNT_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [COUNT_WIDTH-1:0] cfg_len,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_WIDTH-1:0]    in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_sat
);

    localparam int SHIFT = align_shift(IN_EXPONENT, OUT_EXPONENT);
    localparam int ACC_W = acc_width(IN_WIDTH, OUT_WIDTH, COUNT_WIDTH, SHIFT);

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d, aligned, acc_next;
    logic [COUNT_WIDTH-1:0]   cnt_q, cnt_d, len_q, len_d, len_eff, cnt_inc;
    logic [OUT_WIDTH-1:0]     out_data_q, out_data_d;
    logic                     out_sat_q, out_sat_d;
    logic                     in_fire, out_fire, first, last;
    sat_t                     sat_r;

    align_real_sig #(
        .IN_WIDTH    (IN_WIDTH),
        .IN_EXPONENT (IN_EXPONENT),
        .OUT_EXPONENT(OUT_EXPONENT),
        .OUT_WIDTH   (ACC_W)
    ) u_align (
        .data_i(in_data),
        .data_o(aligned)
    );

    assign in_ready  = (state_q == ACC) || out_ready;
    assign out_valid = state_q == DONE;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    // The count is cleared whenever a block completes, so DONE always sees a block start.
    assign first     = cnt_q == '0;
    assign len_eff   = !first ? len_q : (cfg_len == '0 ? COUNT_WIDTH'(1) : cfg_len);
    assign cnt_inc   = cnt_q + 1'b1;
    assign last      = cnt_inc == len_eff;
    assign acc_next  = first ? aligned : acc_q + aligned;
    assign sat_r     = sat_to_width(SAT_W'(acc_next), OUT_WIDTH);
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        if (in_fire) begin
            acc_d   = acc_next;
            len_d   = len_eff;
            cnt_d   = last ? '0 : cnt_inc;
            state_d = last ? DONE : ACC;
            if (last) begin
                out_data_d = sat_r.mant[OUT_WIDTH-1:0];
                out_sat_d  = sat_r.sat;
            end
        end else if (out_fire) begin
            state_d = ACC;
            acc_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACC;
            acc_q      <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end

endmodule

// File: tb/tb_accum_real.sv
// tb_accum_real: vector table, hand-written handshake/reset sequences and a randomized
// run against a block-level model, on a default instance and one with OUT_EXPONENT=-4.
module tb_accum_real;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  cfg_len;
    logic        in_valid, out_ready;
    logic [15:0] in_data;
    logic        in_ready, out_valid, out_sat;
    logic [15:0] out_data;
    logic        in_ready2, out_valid2, out_sat2;
    logic [15:0] out_data2;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    accum_real dut (
        .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat)
    );

    accum_real #(.OUT_EXPONENT(-4)) dut2 (
        .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .out_sat(out_sat2)
    );

    typedef struct {
        int len;
        int n;
        int d[4];
        int q;
        int s;
    } vec_t;

    vec_t tv[9];

    int     m_cnt[2], m_len[2], m_pd[2], m_ps[2];
    bit     m_pend[2];
    longint m_sum[2];

    function automatic vec_t mk(int len, int n, int a, int b, int c, int d, int q, int s);
        vec_t v;
        v.len = len; v.n = n; v.d[0] = a; v.d[1] = b; v.d[2] = c; v.d[3] = d; v.q = q; v.s = s;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int m_align(int k, int d);
        return k == 0 ? d : int'($floor(real'(d) / 16.0));
    endfunction

    function automatic int m_clamp(longint v);
        return v > 32767 ? 32767 : (v < -32768 ? -32768 : int'(v));
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_len[k] = 0; m_sum[k] = 0; m_pend[k] = 0; m_pd[k] = 0; m_ps[k] = 0;
        end
    endtask

    task automatic m_check_and_step();
        int  d;
        bit  ir;
        d = int'($signed(in_data));
        for (int k = 0; k < 2; k++) begin
            ir = !m_pend[k] || out_ready;
            chk(k == 0 ? "rnd_in_ready" : "rnd2_in_ready", k == 0 ? in_ready : in_ready2, ir);
            chk(k == 0 ? "rnd_out_valid" : "rnd2_out_valid", k == 0 ? out_valid : out_valid2, m_pend[k]);
            if (m_pend[k]) begin
                chk(k == 0 ? "rnd_out_data" : "rnd2_out_data",
                    k == 0 ? int'($signed(out_data)) : int'($signed(out_data2)), m_pd[k]);
                chk(k == 0 ? "rnd_out_sat" : "rnd2_out_sat", k == 0 ? out_sat : out_sat2, m_ps[k]);
            end
            if (m_pend[k] && out_ready) m_pend[k] = 0;
            if (in_valid && ir) begin
                if (m_cnt[k] == 0) begin
                    m_len[k] = cfg_len == 0 ? 1 : int'(cfg_len);
                    m_sum[k] = 0;
                end
                m_sum[k] += m_align(k, d);
                m_cnt[k]++;
                if (m_cnt[k] == m_len[k]) begin
                    m_pend[k] = 1;
                    m_pd[k]   = m_clamp(m_sum[k]);
                    m_ps[k]   = (m_sum[k] > 32767 || m_sum[k] < -32768) ? 1 : 0;
                    m_cnt[k]  = 0;
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = mk(4, 4, 256, 256, 256, 256, 1024, 0);
        tv[1] = mk(4, 4, 32767, 32767, 32767, 32767, 32767, 1);
        tv[2] = mk(4, 4, -32768, -32768, -32768, -32768, -32768, 1);
        tv[3] = mk(0, 1, 7, 0, 0, 0, 7, 0);
        tv[4] = mk(0, 1, 9, 0, 0, 0, 9, 0);
        tv[5] = mk(2, 2, 100, -300, 0, 0, -200, 0);
        tv[6] = mk(3, 3, 16384, 16384, -1, 0, 32767, 0);
        tv[7] = mk(2, 2, 16384, 16384, 0, 0, 32767, 1);
        tv[8] = mk(3, 3, -16384, -16384, -1, 0, -32768, 1);

        rst_n = 1'b0; cfg_len = '0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_sat", out_sat, 0);

        cfg_len = 8'd2; in_valid = 1'b1; in_data = 16'd256;
        tick();
        in_data = 16'hFFE8;
        tick();
        in_valid = 1'b0;
        chk("exp4_out_valid", out_valid2, 1);
        chk("exp4_out_data", int'($signed(out_data2)), 14);
        chk("exp0_out_data", int'($signed(out_data)), 232);
        tick();

        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < tv[i].n; j++) begin
                cfg_len = 8'(tv[i].len); in_valid = 1'b1; in_data = 16'(tv[i].d[j]);
                #1 chk("tbl_in_ready", in_ready, 1);
                tick();
            end
            chk($sformatf("tbl%0d_out_valid", i), out_valid, 1);
            chk($sformatf("tbl%0d_out_data", i), int'($signed(out_data)), tv[i].q);
            chk($sformatf("tbl%0d_out_sat", i), out_sat, tv[i].s);
        end
        in_valid = 1'b0;
        tick();
        chk("tbl_drain_out_valid", out_valid, 0);

        cfg_len = 8'd2; in_valid = 1'b1; in_data = 16'd10;
        tick();
        in_data = 16'd20;
        tick();
        out_ready = 1'b0; in_data = 16'd999;
        repeat (5) begin
            #1;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_data", int'($signed(out_data)), 30);
            chk("bp_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1; in_data = 16'd100;
        #1 chk("bp_release_in_ready", in_ready, 1);
        tick();
        chk("bp_taken_out_valid", out_valid, 0);
        in_data = 16'd5;
        tick();
        chk("bp_next_out_valid", out_valid, 1);
        chk("bp_next_out_data", int'($signed(out_data)), 105);
        in_valid = 1'b0;
        tick();

        cfg_len = 8'd4; in_valid = 1'b1; in_data = 16'd256;
        repeat (2) tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_out_data", out_data, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cfg_len = 8'd1; in_valid = 1'b1; in_data = 16'd50; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("rst_done_pre_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1 chk("rst_done_async_drop", out_valid, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1; cfg_len = 8'd4; in_valid = 1'b1; in_data = 16'd1;
        repeat (4) tick();
        in_valid = 1'b0;
        chk("post_rst_out_valid", out_valid, 1);
        chk("post_rst_out_data", int'($signed(out_data)), 4);
        tick();

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            cfg_len   = ($urandom % 16 == 0) ? 8'($urandom) : 8'($urandom % 6);
            case ($urandom % 4)
                0:       in_data = 16'h7FFF;
                1:       in_data = 16'h8000;
                default: in_data = 16'($urandom);
            endcase
            #1;
            m_check_and_step();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
